// File: rtl/acc_sched_pkg.sv
// Shared types and default widths for the round-robin accumulator burst scheduler.
package acc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } acc_sched_state_e;

    localparam int DEF_NREQ = 4;
    localparam int DEF_DW   = 8;
    localparam int DEF_SW   = 16;
    localparam int DEF_LENW = 4;

endpackage

// File: rtl/acc_burst_sched_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr+1 upward (wrapping) and
// grants the first active request, returning one-hot grant plus its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    int  cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[IW'(cand)]) begin
                found            = 1'b1;
                gnt[IW'(cand)]   = 1'b1;
                idx              = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/acc_burst_sched.sv
// Shares one external accumulator between NREQ requesters: arbitrate, clear,
// stream the latched number of words, then publish the tagged final sum.
module acc_burst_sched
    import acc_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    parameter int SW   = DEF_SW,
    parameter int LENW = DEF_LENW,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] req_len,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 acc_rst,
    output logic [DW-1:0]        acc_in,
    input  logic [SW-1:0]        acc_sum,
    output logic                 res_valid,
    output logic [IW-1:0]        res_id,
    output logic [SW-1:0]        res_sum,
    output logic                 busy
);

    acc_sched_state_e state_reg, state_next;
    logic [IW-1:0]    ptr_reg, ptr_next;
    logic [IW-1:0]    id_reg, id_next;
    logic [LENW-1:0]  cnt_reg, cnt_next;
    logic             res_valid_reg;
    logic [IW-1:0]    res_id_reg;
    logic [SW-1:0]    res_sum_reg;

    logic [DW-1:0]    data_arr [NREQ];
    logic [LENW-1:0]  len_arr  [NREQ];
    logic [NREQ-1:0]  arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign data_arr[gi] = req_data[gi*DW +: DW];
            assign len_arr[gi]  = req_len[gi*LENW +: LENW];
            assign gnt[gi]      = (state_reg == BURST) && (id_reg == IW'(gi));
        end
    endgenerate

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req),
        .ptr (ptr_reg),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign arb_any = |arb_gnt;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        id_next    = id_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (arb_any) begin
                    id_next    = arb_idx;
                    ptr_next   = arb_idx;
                    // A zero length field still moves one word.
                    cnt_next   = (len_arr[arb_idx] == '0) ? LENW'(1) : len_arr[arb_idx];
                    state_next = CLEAR;
                end
            end
            CLEAR: state_next = BURST;
            BURST: begin
                if (cnt_reg == LENW'(1)) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - LENW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= IW'(NREQ - 1);
            id_reg        <= '0;
            cnt_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_id_reg    <= '0;
            res_sum_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            id_reg        <= id_next;
            cnt_reg       <= cnt_next;
            res_valid_reg <= (state_reg == DONE);
            // The accumulator has absorbed the last word by the DONE cycle.
            if (state_reg == DONE) begin
                res_sum_reg <= acc_sum;
                res_id_reg  <= id_reg;
            end
        end
    end

    assign acc_rst   = rst | (state_reg == CLEAR);
    assign acc_in    = (state_reg == BURST) ? data_arr[id_reg] : '0;
    assign busy      = (state_reg != IDLE);
    assign res_valid = res_valid_reg;
    assign res_id    = res_id_reg;
    assign res_sum   = res_sum_reg;

endmodule

// File: tb/tb_acc_burst_sched.sv
// Bench: table of directed bursts, reset corner cases, then random bursts
// against a round-robin / summation reference model.
module tb_acc_burst_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_len = '0;
    logic [31:0] req_data = '0;

    logic [3:0]  gnt;
    logic        acc_rst;
    logic [7:0]  acc_in;
    logic [15:0] acc_sum;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [15:0] res_sum;
    logic        busy;

    logic [3:0]  gnt10;
    logic        acc_rst10;
    logic [7:0]  acc_in10;
    logic [9:0]  acc_sum10;
    logic        res_valid10;
    logic [1:0]  res_id10;
    logic [9:0]  res_sum10;
    logic        busy10;

    int n_tests = 0;
    int n_fail  = 0;
    int mptr    = 3;

    always #5 clk = ~clk;

    acc_burst_sched #(.NREQ(4), .DW(8), .SW(16), .LENW(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_data(req_data),
        .gnt(gnt), .acc_rst(acc_rst), .acc_in(acc_in), .acc_sum(acc_sum),
        .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .busy(busy)
    );

    acc_burst_sched #(.NREQ(4), .DW(8), .SW(10), .LENW(4)) dut10 (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_data(req_data),
        .gnt(gnt10), .acc_rst(acc_rst10), .acc_in(acc_in10), .acc_sum(acc_sum10),
        .res_valid(res_valid10), .res_id(res_id10), .res_sum(res_sum10), .busy(busy10)
    );

    // Accumulator instances as the scheduler expects them to behave.
    always @(posedge clk) begin
        acc_sum   <= acc_rst   ? 16'd0 : acc_sum + 16'(acc_in);
        acc_sum10 <= acc_rst10 ? 10'd0 : acc_sum10 + 10'(acc_in10);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at a negedge of an IDLE cycle; leaves at the negedge of the res_valid cycle.
    task automatic run_burst(input logic [3:0] r, input logic [15:0] lens,
                             input logic [31:0] base, input logic [7:0] inc,
                             input bit rnd, input bit hold,
                             output int got_id, output int got_sum, output int got_sum10);
        int win;
        int len;
        int msum;
        logic [7:0] d [4];
        win = -1;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (mptr + k) % 4;
            if (win < 0 && r[c]) win = c;
        end
        mptr = win;
        len  = int'(lens[win*4 +: 4]);
        if (len == 0) len = 1;
        msum = 0;
        chk("idle_busy", 32'(busy), 32'd0);
        req     = r;
        req_len = lens;
        @(posedge clk); @(negedge clk);
        if (!hold) req = '0;
        chk("clear_acc_rst", 32'(acc_rst), 32'd1);
        chk("clear_gnt", 32'(gnt), 32'd0);
        chk("clear_busy", 32'(busy), 32'd1);
        for (int j = 0; j < len; j++) begin
            @(posedge clk); @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                d[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(base[i*8 +: 8] + inc * 8'(j));
                req_data[i*8 +: 8] = d[i];
            end
            if (rnd) req_len = 16'($urandom);
            #1;
            chk("burst_gnt", 32'(gnt), 32'(1 << win));
            chk("burst_acc_in", 32'(acc_in), 32'(d[win]));
            chk("burst_acc_rst", 32'(acc_rst), 32'd0);
            msum += int'(d[win]);
        end
        @(posedge clk); @(negedge clk);
        chk("done_gnt", 32'(gnt), 32'd0);
        chk("done_acc_in", 32'(acc_in), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_id", 32'(res_id), 32'(win));
        chk("res_sum", 32'(res_sum), 32'(msum % 65536));
        chk("res_sum_sw10", 32'(res_sum10), 32'(msum % 1024));
        chk("res_valid_sw10", 32'(res_valid10), 32'd1);
        chk("res_busy", 32'(busy), 32'd0);
        got_id    = int'(res_id);
        got_sum   = int'(res_sum);
        got_sum10 = int'(res_sum10);
    endtask

    typedef struct {
        logic [3:0]  r;
        logic [15:0] lens;
        logic [31:0] base;
        logic [7:0]  inc;
        bit          hold;
        int          exp_id;
        int          exp_sum;
        int          exp_sum10;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d tests expected completion", n_tests);
        $fatal(1);
    end

    initial begin
        int gid, gsum, gsum10;
        // all request, len 1, data i+1
        for (int i = 0; i < 4; i++)
            tbl[i] = '{4'b1111, 16'h1111, 32'h04030201, 8'd0, 1'b0, i, i + 1, i + 1};
        // single burst of requester 2: 5+6+7
        tbl[4] = '{4'b0100, 16'h0300, 32'h00050000, 8'd1, 1'b0, 2, 18, 18};
        // fairness: 0 and 1 held, len 2
        for (int i = 0; i < 6; i++)
            tbl[5+i] = '{4'b0011, 16'h0022, 32'h00002010, 8'd1, 1'b1, i % 2,
                         (i % 2 == 0) ? 33 : 65, (i % 2 == 0) ? 33 : 65};
        // len 0 means one word
        tbl[11] = '{4'b0001, 16'h0000, 32'h00000009, 8'd0, 1'b0, 0, 9, 9};
        // 15 x 255 = 3825, wraps to 753 at 10 bits
        tbl[12] = '{4'b0010, 16'h00F0, 32'h0000FF00, 8'd0, 1'b0, 1, 3825, 753};

        // reset held three cycles
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_acc_rst", 32'(acc_rst), 32'd1);
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_res_sum", 32'(res_sum), 32'd0);
            chk("rst_res_id", 32'(res_id), 32'd0);
            chk("rst_acc_in", 32'(acc_in), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("release_acc_rst", 32'(acc_rst), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 13; v++) begin
            run_burst(tbl[v].r, tbl[v].lens, tbl[v].base, tbl[v].inc, 1'b0, tbl[v].hold,
                      gid, gsum, gsum10);
            chk($sformatf("tbl%0d_id", v), 32'(gid), 32'(tbl[v].exp_id));
            chk($sformatf("tbl%0d_sum", v), 32'(gsum), 32'(tbl[v].exp_sum));
            chk($sformatf("tbl%0d_sum10", v), 32'(gsum10), 32'(tbl[v].exp_sum10));
        end
        req = '0;

        // reset during the 2nd BURST cycle of requester 3
        req = 4'b1000; req_len = 16'h4000;
        @(posedge clk); @(negedge clk);
        req = '0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        #1;
        chk("abort_gnt_before", 32'(gnt), 32'b1000);
        rst = 1'b1;
        #1;
        chk("abort_acc_rst", 32'(acc_rst), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk);
            chk("abort_gnt", 32'(gnt), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_res_valid", 32'(res_valid), 32'd0);
        end
        rst  = 1'b0;
        mptr = 3;
        run_burst(4'b1001, 16'h1111, 32'h07000003, 8'd0, 1'b0, 1'b0, gid, gsum, gsum10);
        chk("after_abort_id", 32'(gid), 32'd0);
        chk("after_abort_sum", 32'(gsum), 32'd3);

        // random bursts against the reference model
        for (int t = 0; t < 40; t++) begin
            run_burst(4'($urandom_range(1, 15)), 16'($urandom), 32'd0, 8'd0, 1'b1,
                      1'($urandom_range(0, 1)), gid, gsum, gsum10);
        end
        req = '0;
        @(posedge clk); @(negedge clk);
        chk("tail_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("tail_busy", 32'(busy), 32'd0);
        chk("tail_res_valid_sw10", 32'(res_valid10), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
